id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID->EX pipeline register and operand-issue stage; directly feeds the ALU (A, B, shamt, one-hot ALUop).
//  Holds one decoded instruction with a valid/allowin handshake.
//  Resolves RAW hazards by forwarding from the MEM and WB stages, and stalls on load-use.
//  Accepts a flush that kills the held instruction.
// PARAMETERS
//  DATA_W    32  operand/result width
//  ALUOP_W   15  one-hot ALU opcode width; bit map comes from the package
//  REG_AW    5   register index width
// PORTS
//  clk            in   1        clock, rising edge
//  rst            in   1        async reset, active-high
//  ds_valid       in   1        ID has an instruction for EX
//  es_allowin     out  1        EX will accept this cycle
//  ds_alu_op      in   ALUOP_W  one-hot op; all-zero = no ALU op
//  ds_rs, ds_rt   in   REG_AW   source register indices
//  ds_src_rs/rt   in   1        instruction reads rs / rt
//  ds_rs_val/rt   in   DATA_W   regfile read values
//  ds_imm         in   DATA_W   extended immediate
//  ds_use_imm     in   1        B = imm instead of rt
//  ds_shamt       in   5        shift amount field
//  ds_dest        in   REG_AW   destination register; 0 = none
//  ds_is_load     in   1        instruction is a load
//  ms_allowin     in   1        MEM stage accepts
//  ms_fw_valid    in   1        MEM holds a valid writer
//  ms_fw_dest     in   REG_AW   MEM destination register
//  ms_fw_value    in   DATA_W   MEM result
//  ms_fw_is_load  in   1        MEM instruction is a load; its value is not ready
//  ws_fw_valid    in   1        WB holds a valid writer
//  ws_fw_dest     in   REG_AW   WB destination register
//  ws_fw_value    in   DATA_W   WB result
//  flush          in   1        kill the held instruction; block ID acceptance this cycle
//  es_valid       out  1        stage holds a live instruction
//  es_to_ms_valid out  1        instruction leaves EX this cycle
//  alu_a, alu_b   out  DATA_W   ALU operands
//  alu_shamt      out  5        ALU shift amount
//  alu_op         out  ALUOP_W  gated by es_valid; 0 when the stage is empty
//  es_dest        out  REG_AW   destination register, passed downstream
//  es_is_load     out  1        load flag, passed downstream
// BEHAVIOUR
//  Reset: all state registers = 0. es_valid=0, alu_op=0, alu_a=alu_b=0, es_dest=0, es_is_load=0, es_allowin=1.
//  Forward select per source s in {rs,rt}; source reg index r:
//   - r==0                                        -> 0
//   - else ms_fw_valid & ms_fw_dest==r            -> ms_fw_value  (MEM has priority)
//   - else ws_fw_valid & ws_fw_dest==r            -> ws_fw_value
//   - else                                        -> stored value
//  Load-use hazard: es_valid & src_s & r!=0 & ms_fw_valid & ms_fw_is_load & ms_fw_dest==r.
//  es_ready_go    = ~hazard
//  es_allowin     = ~es_valid | (es_ready_go & ms_allowin)
//  es_to_ms_valid = es_valid & es_ready_go & ~flush
//  Capture: when ds_valid & es_allowin & ~flush, latch the full payload; es_valid<=1 next cycle.
//  Empty: es_allowin & ~(ds_valid & ~flush) -> es_valid<=0.
//  Flush: es_valid<=0 on the next edge whatever the handshake state. A same-cycle ds_valid is not captured.
//  Stall refresh: while es_valid & ~es_allowin, the stored rs/rt values are overwritten each cycle with the
//   forwarded values. A WB value seen during a stall is therefore kept after WB retires.
//  Outputs (combinational from stored state + forward nets):
//   - alu_a = fwd(rs)
//   - alu_b = use_imm ? imm : fwd(rt)
//   - alu_shamt = stored shamt; alu_op = stored op & {ALUOP_W{es_valid}}
//  Latency: 1 cycle ID->ALU inputs. No loss or duplication under any ms_allowin pattern.
//  Reset asserted mid-stall: state clears immediately (async); no output is held.
// STRUCTURE
//  Package cpu_pkg:
//   - ALU op bit indices OP_AND=0, OP_OR=1, OP_XOR=2, OP_NOR=3, OP_ADD=4, OP_SUB=5, OP_SLT=6, OP_SLL=7,
//     OP_SRL=8, OP_SLLV=9, OP_SRLV=10, OP_SLTU=11, OP_LUI=12, OP_SRA=13, OP_SRAV=14
//   - ALUOP_W, DATA_W, REG_AW
//  Sub-module fwd_mux: index, stored value, MS/WS buses -> forwarded value + load-hit flag. Instantiated for rs and rt.
// TESTING
//  1 add $3,$1,$2: rs=0x5, rt=0x7, ms_allowin=1 -> next cycle alu_a=5, alu_b=7, alu_op=1<<4, es_to_ms_valid=1.
//  2 ms_fw dest=1 value=0xAA and ws_fw dest=1 value=0xBB -> alu_a=0xAA (MEM wins); dest=0 match -> alu_a=0.
//  3 MEM load with dest=2; EX reads rt=2:
//     - es_to_ms_valid=0 and es_allowin=0 for 1 cycle
//     - next cycle MEM is empty and WB dest=2 value=0x1234 -> alu_b=0x1234
//     - WB then retires -> alu_b stays 0x1234
//  4 ms_allowin=0 for 3 cycles with ds_valid=1 -> payload held, es_allowin=0, no new capture; release -> one transfer.
//  5 flush during the stall, with ds_valid=1 -> next cycle es_valid=0, alu_op=0, ID instruction not captured.
//  6 rst pulse mid-stream -> es_valid=0, alu_op=0, alu_a=alu_b=0 asynchronously.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared datapath widths and one-hot ALU opcode bit positions
package cpu_pkg;
  localparam int DATA_W  = 32;
  localparam int ALUOP_W = 15;
  localparam int REG_AW  = 5;
  localparam int OP_AND  = 0;
  localparam int OP_OR   = 1;
  localparam int OP_XOR  = 2;
  localparam int OP_NOR  = 3;
  localparam int OP_ADD  = 4;
  localparam int OP_SUB  = 5;
  localparam int OP_SLT  = 6;
  localparam int OP_SLL  = 7;
  localparam int OP_SRL  = 8;
  localparam int OP_SLLV = 9;
  localparam int OP_SRLV = 10;
  localparam int OP_SLTU = 11;
  localparam int OP_LUI  = 12;
  localparam int OP_SRA  = 13;
  localparam int OP_SRAV = 14;
endpackage

// File: rtl/fwd_mux.sv
// fwd_mux: picks the freshest value of one source register from MEM/WB bypass or the stored copy
module fwd_mux
  import cpu_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = REG_AW
) (
  input  logic [AW-1:0] idx_i,
  input  logic          src_i,
  input  logic [DW-1:0] stored_i,
  input  logic          ms_valid_i,
  input  logic [AW-1:0] ms_dest_i,
  input  logic [DW-1:0] ms_value_i,
  input  logic          ms_is_load_i,
  input  logic          ws_valid_i,
  input  logic [AW-1:0] ws_dest_i,
  input  logic [DW-1:0] ws_value_i,
  output logic [DW-1:0] val_o,
  output logic          load_hit_o
);
  logic nz, ms_hit, ws_hit;
  assign nz         = |idx_i;
  assign ms_hit     = nz & ms_valid_i & (ms_dest_i == idx_i);
  assign ws_hit     = nz & ws_valid_i & (ws_dest_i == idx_i);
  assign val_o      = !nz ? '0 : ms_hit ? ms_value_i : ws_hit ? ws_value_i : stored_i;
  assign load_hit_o = src_i & ms_hit & ms_is_load_i;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID->EX pipeline register with MEM/WB forwarding, load-use stall and flush
module id_ex_stage #(
  parameter int DATA_W  = cpu_pkg::DATA_W,
  parameter int ALUOP_W = cpu_pkg::ALUOP_W,
  parameter int REG_AW  = cpu_pkg::REG_AW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ds_valid,
  output logic               es_allowin,
  input  logic [ALUOP_W-1:0] ds_alu_op,
  input  logic [REG_AW-1:0]  ds_rs,
  input  logic [REG_AW-1:0]  ds_rt,
  input  logic               ds_src_rs,
  input  logic               ds_src_rt,
  input  logic [DATA_W-1:0]  ds_rs_val,
  input  logic [DATA_W-1:0]  ds_rt_val,
  input  logic [DATA_W-1:0]  ds_imm,
  input  logic               ds_use_imm,
  input  logic [4:0]         ds_shamt,
  input  logic [REG_AW-1:0]  ds_dest,
  input  logic               ds_is_load,
  input  logic               ms_allowin,
  input  logic               ms_fw_valid,
  input  logic [REG_AW-1:0]  ms_fw_dest,
  input  logic [DATA_W-1:0]  ms_fw_value,
  input  logic               ms_fw_is_load,
  input  logic               ws_fw_valid,
  input  logic [REG_AW-1:0]  ws_fw_dest,
  input  logic [DATA_W-1:0]  ws_fw_value,
  input  logic               flush,
  output logic               es_valid,
  output logic               es_to_ms_valid,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic [4:0]         alu_shamt,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [REG_AW-1:0]  es_dest,
  output logic               es_is_load
);
  typedef struct packed {
    logic [ALUOP_W-1:0] op;
    logic [REG_AW-1:0]  rs;
    logic [REG_AW-1:0]  rt;
    logic               src_rs;
    logic               src_rt;
    logic [DATA_W-1:0]  rs_val;
    logic [DATA_W-1:0]  rt_val;
    logic [DATA_W-1:0]  imm;
    logic               use_imm;
    logic [4:0]         shamt;
    logic [REG_AW-1:0]  dest;
    logic               is_load;
  } payload_t;
  payload_t pl_q, pl_d;
  logic valid_q, valid_d;
  logic [DATA_W-1:0] fwd_rs, fwd_rt;
  logic hit_rs, hit_rt, ready_go;
  fwd_mux #(.DW(DATA_W), .AW(REG_AW)) u_fwd_rs (
    .idx_i(pl_q.rs), .src_i(pl_q.src_rs), .stored_i(pl_q.rs_val),
    .ms_valid_i(ms_fw_valid), .ms_dest_i(ms_fw_dest), .ms_value_i(ms_fw_value), .ms_is_load_i(ms_fw_is_load),
    .ws_valid_i(ws_fw_valid), .ws_dest_i(ws_fw_dest), .ws_value_i(ws_fw_value),
    .val_o(fwd_rs), .load_hit_o(hit_rs)
  );
  fwd_mux #(.DW(DATA_W), .AW(REG_AW)) u_fwd_rt (
    .idx_i(pl_q.rt), .src_i(pl_q.src_rt), .stored_i(pl_q.rt_val),
    .ms_valid_i(ms_fw_valid), .ms_dest_i(ms_fw_dest), .ms_value_i(ms_fw_value), .ms_is_load_i(ms_fw_is_load),
    .ws_valid_i(ws_fw_valid), .ws_dest_i(ws_fw_dest), .ws_value_i(ws_fw_value),
    .val_o(fwd_rt), .load_hit_o(hit_rt)
  );
  assign ready_go       = ~(valid_q & (hit_rs | hit_rt));
  assign es_allowin     = ~valid_q | (ready_go & ms_allowin);
  assign es_to_ms_valid = valid_q & ready_go & ~flush;
  assign es_valid       = valid_q;
  assign alu_a          = fwd_rs;
  assign alu_b          = pl_q.use_imm ? pl_q.imm : fwd_rt;
  assign alu_shamt      = pl_q.shamt;
  assign alu_op         = pl_q.op & {ALUOP_W{valid_q}};
  assign es_dest        = pl_q.dest;
  assign es_is_load     = pl_q.is_load;
  always_comb begin
    valid_d = ~flush & (es_allowin ? ds_valid : valid_q);
    pl_d    = pl_q;
    if (ds_valid & es_allowin & ~flush)
      pl_d = '{op: ds_alu_op, rs: ds_rs, rt: ds_rt, src_rs: ds_src_rs, src_rt: ds_src_rt,
               rs_val: ds_rs_val, rt_val: ds_rt_val, imm: ds_imm, use_imm: ds_use_imm,
               shamt: ds_shamt, dest: ds_dest, is_load: ds_is_load};
    else if (valid_q & ~es_allowin) begin
      // refresh so a bypass value seen while stalled survives its producer retiring
      pl_d.rs_val = fwd_rs;
      pl_d.rt_val = fwd_rt;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid_q <= 1'b0;
      pl_q    <= '0;
    end else begin
      valid_q <= valid_d;
      pl_q    <= pl_d;
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed scenarios plus randomized traffic checked against an instruction-level model
module tb_id_ex_stage;
  import cpu_pkg::*;
  logic clk = 0, rst = 0;
  always #5 clk = ~clk;
  logic ds_valid, ms_allowin, flush, ds_src_rs, ds_src_rt, ds_use_imm, ds_is_load;
  logic ms_fw_valid, ms_fw_is_load, ws_fw_valid;
  logic [14:0] ds_alu_op;
  logic [4:0] ds_rs, ds_rt, ds_dest, ds_shamt, ms_fw_dest, ws_fw_dest;
  logic [31:0] ds_rs_val, ds_rt_val, ds_imm, ms_fw_value, ws_fw_value;
  logic es_allowin, es_valid, es_to_ms_valid, es_is_load;
  logic [31:0] alu_a, alu_b;
  logic [4:0] alu_shamt, es_dest;
  logic [14:0] alu_op;
  int total = 0, bad = 0;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .ds_valid(ds_valid), .es_allowin(es_allowin), .ds_alu_op(ds_alu_op),
    .ds_rs(ds_rs), .ds_rt(ds_rt), .ds_src_rs(ds_src_rs), .ds_src_rt(ds_src_rt),
    .ds_rs_val(ds_rs_val), .ds_rt_val(ds_rt_val), .ds_imm(ds_imm), .ds_use_imm(ds_use_imm),
    .ds_shamt(ds_shamt), .ds_dest(ds_dest), .ds_is_load(ds_is_load), .ms_allowin(ms_allowin),
    .ms_fw_valid(ms_fw_valid), .ms_fw_dest(ms_fw_dest), .ms_fw_value(ms_fw_value),
    .ms_fw_is_load(ms_fw_is_load), .ws_fw_valid(ws_fw_valid), .ws_fw_dest(ws_fw_dest),
    .ws_fw_value(ws_fw_value), .flush(flush), .es_valid(es_valid), .es_to_ms_valid(es_to_ms_valid),
    .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt), .alu_op(alu_op), .es_dest(es_dest),
    .es_is_load(es_is_load)
  );

  // Reference model: one held instruction record with its (possibly refreshed) operand values
  typedef struct packed {
    logic v; logic [14:0] op; logic [4:0] rs, rt; logic srs, srt;
    logic [31:0] a, b, imm; logic ui; logic [4:0] sh, dest; logic ld;
  } ins_t;
  ins_t m;

  function automatic logic [31:0] mfwd(input logic [4:0] r, input logic [31:0] s);
    if (r == 0) return 32'd0;
    if (ms_fw_valid && ms_fw_dest == r) return ms_fw_value;
    if (ws_fw_valid && ws_fw_dest == r) return ws_fw_value;
    return s;
  endfunction
  function automatic logic mstall();
    logic lr = ms_fw_valid && ms_fw_is_load;
    return m.v && ((m.srs && m.rs != 0 && lr && ms_fw_dest == m.rs) ||
                   (m.srt && m.rt != 0 && lr && ms_fw_dest == m.rt));
  endfunction
  function automatic logic mallow();
    return !m.v || (!mstall() && ms_allowin);
  endfunction
  function automatic ins_t mnext();
    ins_t t = m;
    if (mallow() && ds_valid && !flush)
      return '{1'b1, ds_alu_op, ds_rs, ds_rt, ds_src_rs, ds_src_rt, ds_rs_val, ds_rt_val,
               ds_imm, ds_use_imm, ds_shamt, ds_dest, ds_is_load};
    if (m.v && !mallow()) begin
      t.a = mfwd(m.rs, m.a);
      t.b = mfwd(m.rt, m.b);
    end
    if (flush || mallow()) t.v = 1'b0;
    return t;
  endfunction
  always @(posedge clk or posedge rst)
    if (rst) m <= '0;
    else m <= mnext();

  task automatic idle();
    ds_valid = 0; ds_alu_op = 0; ds_rs = 0; ds_rt = 0; ds_src_rs = 0; ds_src_rt = 0;
    ds_rs_val = 0; ds_rt_val = 0; ds_imm = 0; ds_use_imm = 0; ds_shamt = 0; ds_dest = 0;
    ds_is_load = 0; ms_allowin = 1; flush = 0; ms_fw_valid = 0; ms_fw_dest = 0;
    ms_fw_value = 0; ms_fw_is_load = 0; ws_fw_valid = 0; ws_fw_dest = 0; ws_fw_value = 0;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic load(input int op, input logic [4:0] rs, rt, input logic [31:0] rsv, rtv, imm,
                      input logic ui, input logic [4:0] dest);
    ds_valid = 1; ds_alu_op = 15'(1 << op); ds_rs = rs; ds_rt = rt; ds_src_rs = 1; ds_src_rt = 1;
    ds_rs_val = rsv; ds_rt_val = rtv; ds_imm = imm; ds_use_imm = ui; ds_shamt = 5'd3;
    ds_dest = dest; ds_is_load = 0;
  endtask

  task automatic test_reset();
    idle();
    #1 rst = 1;
    #1;
    total++;
    if ({es_valid, alu_op, alu_a, alu_b, es_dest, es_is_load, es_to_ms_valid} !== '0) begin
      bad++; $display("FAIL reset_state got v=%b op=%h a=%h b=%h dest=%h ld=%b want all zero",
                      es_valid, alu_op, alu_a, alu_b, es_dest, es_is_load);
    end
    total++;
    if (es_allowin !== 1'b1) begin bad++; $display("FAIL reset_allowin got %b want 1", es_allowin); end
    step();
    rst = 0;
    step();
  endtask

  task automatic test_add();
    load(OP_ADD, 5'd1, 5'd2, 32'h5, 32'h7, 32'h0, 1'b0, 5'd3);
    step();
    total++;
    if (alu_a !== 32'h5) begin bad++; $display("FAIL add_a got %h want 5", alu_a); end
    total++;
    if (alu_b !== 32'h7) begin bad++; $display("FAIL add_b got %h want 7", alu_b); end
    total++;
    if (alu_op !== 15'h10) begin bad++; $display("FAIL add_op got %h want 0010", alu_op); end
    total++;
    if (es_to_ms_valid !== 1'b1) begin bad++; $display("FAIL add_to_ms got %b want 1", es_to_ms_valid); end
    idle();
    step();
  endtask

  task automatic test_forward_priority();
    load(OP_ADD, 5'd1, 5'd2, 32'h5, 32'h7, 32'h0, 1'b0, 5'd3);
    step();
    ds_valid = 0;
    ms_fw_valid = 1; ms_fw_dest = 5'd1; ms_fw_value = 32'hAA;
    ws_fw_valid = 1; ws_fw_dest = 5'd1; ws_fw_value = 32'hBB;
    #1;
    total++;
    if (alu_a !== 32'hAA) begin bad++; $display("FAIL fwd_mem_wins got %h want aa", alu_a); end
    ms_fw_valid = 0;
    #1;
    total++;
    if (alu_a !== 32'hBB) begin bad++; $display("FAIL fwd_wb got %h want bb", alu_a); end
    idle();
    step();
    load(OP_ADD, 5'd0, 5'd2, 32'h55, 32'h7, 32'h0, 1'b0, 5'd3);
    step();
    ds_valid = 0;
    ms_fw_valid = 1; ms_fw_dest = 5'd0; ms_fw_value = 32'hAA;
    ws_fw_valid = 1; ws_fw_dest = 5'd0; ws_fw_value = 32'hBB;
    #1;
    total++;
    if (alu_a !== 32'h0) begin bad++; $display("FAIL fwd_r0 got %h want 0", alu_a); end
    idle();
    step();
  endtask

  task automatic test_load_use();
    load(OP_ADD, 5'd1, 5'd2, 32'h5, 32'h11, 32'h0, 1'b0, 5'd6);
    step();
    ds_valid = 0;
    ms_fw_valid = 1; ms_fw_dest = 5'd2; ms_fw_value = 32'hDEAD; ms_fw_is_load = 1;
    #1;
    total++;
    if ({es_to_ms_valid, es_allowin} !== 2'b00) begin
      bad++; $display("FAIL lu_stall got to_ms=%b allowin=%b want 0 0", es_to_ms_valid, es_allowin);
    end
    step();
    ms_fw_valid = 0; ms_fw_is_load = 0;
    ws_fw_valid = 1; ws_fw_dest = 5'd2; ws_fw_value = 32'h1234; ms_allowin = 0;
    #1;
    total++;
    if (alu_b !== 32'h1234) begin bad++; $display("FAIL lu_wb_fwd got %h want 1234", alu_b); end
    step();
    ws_fw_valid = 0;
    #1;
    total++;
    if (alu_b !== 32'h1234) begin bad++; $display("FAIL lu_wb_kept got %h want 1234", alu_b); end
    ms_allowin = 1;
    #1;
    total++;
    if (es_to_ms_valid !== 1'b1) begin bad++; $display("FAIL lu_release got %b want 1", es_to_ms_valid); end
    idle();
    step();
  endtask

  task automatic test_back_to_back();
    load(OP_OR, 5'd1, 5'd2, 32'h1, 32'h2, 32'h100, 1'b1, 5'd4);
    step();
    load(OP_XOR, 5'd3, 5'd4, 32'h3, 32'h4, 32'h200, 1'b1, 5'd5);
    ms_allowin = 0;
    repeat (3) begin
      #1;
      total++;
      if ({es_allowin, es_to_ms_valid, alu_b, es_dest} !== {1'b0, 1'b1, 32'h100, 5'd4}) begin
        bad++; $display("FAIL hold got allowin=%b b=%h dest=%0d want 0 100 4", es_allowin, alu_b, es_dest);
      end
      step();
    end
    ms_allowin = 1;
    #1;
    total++;
    if ({es_to_ms_valid, alu_b} !== {1'b1, 32'h100}) begin
      bad++; $display("FAIL release_a got to_ms=%b b=%h want 1 100", es_to_ms_valid, alu_b);
    end
    step();
    ds_valid = 0;
    #1;
    total++;
    if ({es_to_ms_valid, alu_b, es_dest} !== {1'b1, 32'h200, 5'd5}) begin
      bad++; $display("FAIL release_b got to_ms=%b b=%h dest=%0d want 1 200 5", es_to_ms_valid, alu_b, es_dest);
    end
    step();
    total++;
    if (es_valid !== 1'b0) begin bad++; $display("FAIL no_dup got %b want 0", es_valid); end
    idle();
  endtask

  task automatic test_flush();
    load(OP_AND, 5'd1, 5'd2, 32'h1, 32'h2, 32'h300, 1'b1, 5'd7);
    step();
    load(OP_SUB, 5'd3, 5'd4, 32'h3, 32'h4, 32'h400, 1'b1, 5'd8);
    ms_allowin = 0;
    step();
    flush = 1;
    #1;
    total++;
    if (es_to_ms_valid !== 1'b0) begin bad++; $display("FAIL flush_to_ms got %b want 0", es_to_ms_valid); end
    step();
    flush = 0; ds_valid = 0;
    #1;
    total++;
    if ({es_valid, alu_op, es_allowin} !== {1'b0, 15'h0, 1'b1}) begin
      bad++; $display("FAIL flush_kill got v=%b op=%h allowin=%b want 0 0 1", es_valid, alu_op, es_allowin);
    end
    idle();
    step();
  endtask

  task automatic test_async_reset();
    load(OP_SUB, 5'd1, 5'd2, 32'h5A5A, 32'h6B6B, 32'h0, 1'b0, 5'd9);
    ms_allowin = 0;
    step();
    ds_valid = 0;
    #2 rst = 1;
    #1;
    total++;
    if ({es_valid, alu_op, alu_a, alu_b} !== '0) begin
      bad++; $display("FAIL async_rst got v=%b op=%h a=%h b=%h want 0", es_valid, alu_op, alu_a, alu_b);
    end
    #1 rst = 0;
    idle();
    step();
  endtask

  task automatic test_random();
    logic [31:0] ea, eb;
    for (int i = 0; i < 400; i++) begin
      ds_valid = 1'($urandom_range(0, 1));
      ds_alu_op = ($urandom_range(0, 7) == 0) ? 15'h0 : 15'(1 << $urandom_range(0, 14));
      ds_rs = 5'($urandom_range(0, 3)); ds_rt = 5'($urandom_range(0, 3));
      ds_src_rs = 1'($urandom_range(0, 1)); ds_src_rt = 1'($urandom_range(0, 1));
      ds_rs_val = $urandom; ds_rt_val = $urandom; ds_imm = $urandom;
      ds_use_imm = 1'($urandom_range(0, 1)); ds_shamt = 5'($urandom);
      ds_dest = 5'($urandom_range(0, 3)); ds_is_load = 1'($urandom_range(0, 1));
      ms_allowin = ($urandom_range(0, 3) != 0); flush = ($urandom_range(0, 15) == 0);
      ms_fw_valid = 1'($urandom_range(0, 1)); ms_fw_dest = 5'($urandom_range(0, 3));
      ms_fw_value = $urandom; ms_fw_is_load = ($urandom_range(0, 2) == 0);
      ws_fw_valid = 1'($urandom_range(0, 1)); ws_fw_dest = 5'($urandom_range(0, 3));
      ws_fw_value = $urandom;
      @(negedge clk);
      ea = mfwd(m.rs, m.a);
      eb = m.ui ? m.imm : mfwd(m.rt, m.b);
      total++;
      if ({es_valid, es_allowin, es_to_ms_valid, alu_op, es_dest, es_is_load, alu_shamt} !==
          {m.v, mallow(), m.v && !mstall() && !flush, m.v ? m.op : 15'h0, m.dest, m.ld, m.sh}) begin
        bad++; $display("FAIL rnd_ctrl cyc=%0d got v=%b al=%b tm=%b op=%h d=%0d ld=%b sh=%0d want v=%b al=%b op=%h d=%0d",
                        i, es_valid, es_allowin, es_to_ms_valid, alu_op, es_dest, es_is_load, alu_shamt,
                        m.v, mallow(), m.v ? m.op : 15'h0, m.dest);
      end
      total++;
      if (alu_a !== ea) begin bad++; $display("FAIL rnd_a cyc=%0d got %h want %h", i, alu_a, ea); end
      total++;
      if (alu_b !== eb) begin bad++; $display("FAIL rnd_b cyc=%0d got %h want %h", i, alu_b, eb); end
      step();
    end
    idle();
    step();
  endtask

  initial begin
    test_reset();
    test_add();
    test_forward_priority();
    test_load_use();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
